// File: rtl/mod_m_cnt.sv
// Free-running modulo-M counter with a one-cycle terminal-count tick.
// max_tic is either decoded from q or registered from next_q; both give the same waveform.
module mod_m_cnt #(
  parameter int M        = 10,
  parameter int TICK_REG = 0,
  localparam int W       = (M > 2) ? $clog2(M) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] q,
  output logic         max_tic
);

  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  generate
    if (M < 2) begin : g_bad_modulus
      $error("mod_m_cnt: modulus M must be >= 2");
    end
  endgenerate

  // Magnitude compare also flushes illegal values (>= M) back to zero.
  always_comb begin
    q_next = '0;
    if (q_reg < LAST) begin
      q_next = q_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

  generate
    if (TICK_REG != 0) begin : g_tick_reg
      logic tic_reg;

      // Loading from next_q keeps the registered tick aligned with q == M-1.
      always_ff @(posedge clk) begin
        if (!rst) begin
          tic_reg <= 1'b0;
        end else begin
          tic_reg <= (q_next == LAST);
        end
      end

      assign max_tic = tic_reg;
    end else begin : g_tick_comb
      assign max_tic = (q_reg == LAST);
    end
  endgenerate

endmodule

// File: tb/tb_mod_m_cnt.sv
// Scoreboard bench for mod_m_cnt: several parameterisations run side by side,
// expected values are queued by a reference model and popped after each edge.
module tb_mod_m_cnt;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q10, q10r;
  logic       t10, t10r;
  logic [2:0] q8a, q8b;
  logic       t8a, t8b;
  logic [0:0] q2;
  logic       t2;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int q10; bit t10;
    int q8;  bit t8;
    int q2;  bit t2;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   mq10 = 0, mq8 = 0, mq2 = 0;

  always #10 clk = ~clk;

  mod_m_cnt #(.M(10), .TICK_REG(0)) dut10  (.clk(clk), .rst(rst), .q(q10),  .max_tic(t10));
  mod_m_cnt #(.M(10), .TICK_REG(1)) dut10r (.clk(clk), .rst(rst), .q(q10r), .max_tic(t10r));
  mod_m_cnt #(.M(8),  .TICK_REG(0)) dut8a  (.clk(clk), .rst(rst), .q(q8a),  .max_tic(t8a));
  mod_m_cnt #(.M(8),  .TICK_REG(1)) dut8b  (.clk(clk), .rst(rst), .q(q8b),  .max_tic(t8b));
  mod_m_cnt #(.M(2),  .TICK_REG(0)) dut2   (.clk(clk), .rst(rst), .q(q2),   .max_tic(t2));

  function automatic int nxt(input int cur, input int m, input bit r);
    if (!r) return 0;
    if (cur >= m - 1) return 0;
    return cur + 1;
  endfunction

  // Drive rst, queue the model's expectation, then advance one edge and sample 1 ns later.
  task automatic tick(input bit r);
    exp_t x;
    rst  = r;
    mq10 = nxt(mq10, 10, r);
    mq8  = nxt(mq8, 8, r);
    mq2  = nxt(mq2, 2, r);
    x.q10 = mq10; x.t10 = (mq10 == 9);
    x.q8  = mq8;  x.t8  = (mq8 == 7);
    x.q2  = mq2;  x.t2  = (mq2 == 1);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      e = exp_q.pop_front();
      vectors++;
      if (q10 !== 4'(e.q10) || t10 !== e.t10 || q10r !== 4'(e.q10) || t10r !== e.t10 ||
          q8a !== 3'(e.q8) || q8b !== 3'(e.q8) || q2 !== 1'(e.q2) || t2 !== e.t2) begin
        miscompares++;
        $display("FAIL reset edge %0d: q10=%0d t10=%b q10r=%0d t10r=%b q8a=%0d q8b=%0d q2=%0d, expected all zero",
                 i, q10, t10, q10r, t10r, q8a, q8b, q2);
      end
    end
    for (int i = 0; i < 11; i++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      vectors++;
      if (q10 !== 4'(e.q10) || t10 !== e.t10) begin
        miscompares++;
        $display("FAIL count_after_release step %0d: q=%0d tic=%b, expected q=%0d tic=%b",
                 i, q10, t10, e.q10, e.t10);
      end else begin
        $display("release step %0d: q=%0d tic=%b", i, q10, t10);
      end
    end
  endtask

  task automatic test_free_run();
    int pulses = 0;
    int last_pulse = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      vectors++;
      if (q10 !== 4'(e.q10) || t10 !== e.t10 || q10r !== 4'(e.q10) || t10r !== e.t10 || q10 > 4'd9) begin
        miscompares++;
        $display("FAIL free_run cycle %0d: q=%0d tic=%b qr=%0d ticr=%b, expected q=%0d tic=%b",
                 i, q10, t10, q10r, t10r, e.q10, e.t10);
      end
      if (t10 === 1'b1) begin
        if (last_pulse >= 0) begin
          vectors++;
          if (i - last_pulse != 10) begin
            miscompares++;
            $display("FAIL tick_period: got %0d cycles, expected 10", i - last_pulse);
          end
        end
        last_pulse = i;
        pulses++;
      end
    end
    vectors++;
    if (pulses != 3) begin
      miscompares++;
      $display("FAIL tick_count: got %0d pulses in 30 cycles, expected 3", pulses);
    end
    $display("free_run: %0d tick pulses in 30 cycles", pulses);
  endtask

  task automatic test_reset_at_tc();
    for (int i = 0; i < 12 && mq10 != 9; i++) begin
      tick(1'b1);
      void'(exp_q.pop_front());
    end
    vectors++;
    if (q10 !== 4'd9 || t10 !== 1'b1 || t10r !== 1'b1) begin
      miscompares++;
      $display("FAIL tc_before_reset: q=%0d tic=%b ticr=%b, expected q=9 tic=1", q10, t10, t10r);
    end
    tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (q10 !== 4'(e.q10) || t10 !== e.t10 || q10r !== 4'(e.q10) || t10r !== e.t10) begin
        miscompares++;
        $display("FAIL reset_at_tc step %0d: q=%0d tic=%b ticr=%b, expected q=%0d tic=%b",
                 i, q10, t10, t10r, e.q10, e.t10);
      end else begin
        $display("reset_at_tc step %0d: q=%0d tic=%b", i, q10, t10);
      end
      tick(1'b1);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_hold();
    for (int i = 0; i < 12 && mq10 != 4; i++) begin
      tick(1'b1);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      e = exp_q.pop_front();
      vectors++;
      if (q10 !== 4'(e.q10) || t10 !== e.t10 || t10r !== e.t10 || e.q10 != 0) begin
        miscompares++;
        $display("FAIL reset_hold edge %0d: q=%0d tic=%b ticr=%b, expected q=0 tic=0", i, q10, t10, t10r);
      end
    end
    tick(1'b1);
    e = exp_q.pop_front();
    vectors++;
    if (q10 !== 4'(e.q10)) begin
      miscompares++;
      $display("FAIL reset_hold_release: q=%0d, expected %0d", q10, e.q10);
    end
  endtask

  task automatic test_pow2();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      vectors++;
      if (q8a !== 3'(e.q8) || t8a !== e.t8 || q8b !== 3'(e.q8) || t8b !== e.t8) begin
        miscompares++;
        $display("FAIL pow2 cycle %0d: comb q=%0d tic=%b reg q=%0d tic=%b, expected q=%0d tic=%b",
                 i, q8a, t8a, q8b, t8b, e.q8, e.t8);
      end else begin
        $display("pow2 cycle %0d: q=%0d tic=%b", i, q8a, t8a);
      end
    end
  endtask

  task automatic test_m2();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      vectors++;
      if (q2 !== 1'(e.q2) || t2 !== e.t2 || t2 !== q2[0]) begin
        miscompares++;
        $display("FAIL m2 cycle %0d: q=%0d tic=%b, expected q=%0d tic=%b", i, q2, t2, e.q2, e.t2);
      end else begin
        $display("m2 cycle %0d: q=%0d tic=%b", i, q2, t2);
      end
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 12 && mq10 != 3; i++) begin
      tick(1'b1);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    force dut10.q_reg  = 4'd12;
    force dut10r.q_reg = 4'd12;
    #1;
    release dut10.q_reg;
    release dut10r.q_reg;
    mq10 = 12;
    #1;
    vectors++;
    if (q10 !== 4'd12 || t10 !== 1'b0 || t10r !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_hold: q=%0d tic=%b ticr=%b, expected q=12 tic=0", q10, t10, t10r);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      e = exp_q.pop_front();
      vectors++;
      if (q10 !== 4'(e.q10) || t10 !== e.t10 || q10r !== 4'(e.q10) || t10r !== e.t10) begin
        miscompares++;
        $display("FAIL illegal_recover step %0d: q=%0d qr=%0d tic=%b, expected q=%0d tic=%b",
                 i, q10, q10r, t10, e.q10, e.t10);
      end else begin
        $display("illegal_recover step %0d: q=%0d", i, q10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_reset_at_tc();
    test_reset_hold();
    test_pow2();
    test_m2();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
